// File: rtl/pid_ctrl_gen.sv
// pid_ctrl_gen: three-stage PID steering controller turning a heading error and forward speed into left/right motor speeds.
// Optional macro FF_RAMP_EN: the forward speed passes through a rate-limited ramp register before stage 2.
module pid_ctrl_gen #(
   parameter int ERR_W     = 12,
   parameter int SAT_W     = 10,
   parameter int FRWRD_W   = 10,
   parameter int INT_W     = 15,
   parameter int I_FRAC    = 6,
   parameter int D_DEPTH   = 3,
   parameter int MAX_SPD   = 1023,
   parameter int RAMP_STEP = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    moving,
   input  logic                    err_vld,
   input  logic signed [ERR_W-1:0] error,
   input  logic [FRWRD_W-1:0]      frwrd,
   input  logic [5:0]              p_coeff,
   input  logic [4:0]              d_coeff,
   output logic [FRWRD_W:0]        lft_spd,
   output logic [FRWRD_W:0]        rght_spd,
   output logic                    spd_vld,
   output logic                    int_sat
);

   localparam int PID_W = SAT_W + 6;
   localparam int DT_W  = 14;
   localparam int SUM_W = FRWRD_W + 4;

   localparam logic signed [ERR_W-1:0] ERR_HI = {{(ERR_W-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
   localparam logic signed [ERR_W-1:0] ERR_LO = {{(ERR_W-SAT_W+1){1'b1}}, {(SAT_W-1){1'b0}}};
   localparam logic signed [SAT_W:0]   DF_HI  = {{(SAT_W-6){1'b0}}, 7'h7F};
   localparam logic signed [SAT_W:0]   DF_LO  = {{(SAT_W-6){1'b1}}, 7'h00};
   localparam logic signed [INT_W:0]   INT_HI = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic signed [INT_W:0]   INT_LO = {2'b11, {(INT_W-1){1'b0}}};
   localparam logic signed [SUM_W-1:0] SPD_HI = SUM_W'(MAX_SPD);

   if (D_DEPTH < 1 || RAMP_STEP < 1) begin : g_param_check
      $error("pid_ctrl_gen: D_DEPTH and RAMP_STEP must be at least 1");
   end

   function automatic logic signed [SAT_W-1:0] sat_err(input logic signed [ERR_W-1:0] x);
      if (x > ERR_HI)      return ERR_HI[SAT_W-1:0];
      else if (x < ERR_LO) return ERR_LO[SAT_W-1:0];
      else                 return x[SAT_W-1:0];
   endfunction

   function automatic logic signed [7:0] sat8(input logic signed [SAT_W:0] x);
      if (x > DF_HI)      return DF_HI[7:0];
      else if (x < DF_LO) return DF_LO[7:0];
      else                return x[7:0];
   endfunction

   function automatic logic signed [INT_W-1:0] clamp_int(input logic signed [INT_W:0] x);
      if (x > INT_HI)      return INT_HI[INT_W-1:0];
      else if (x < INT_LO) return INT_LO[INT_W-1:0];
      else                 return x[INT_W-1:0];
   endfunction

   function automatic logic [FRWRD_W:0] clamp_spd(input logic signed [SUM_W-1:0] x);
      if (x[SUM_W-1])      return '0;
      else if (x > SPD_HI) return SPD_HI[FRWRD_W:0];
      else                 return x[FRWRD_W:0];
   endfunction

   logic signed [SAT_W-1:0] err_sat_p0;
   logic                    vld_p0;
   logic signed [PID_W-1:0] pid_p1;
   logic                    vld_p1;
   logic signed [INT_W-1:0] integ;
   logic signed [SAT_W-1:0] hist [D_DEPTH];
   logic [FRWRD_W-1:0]      f_val;

   logic signed [PID_W-1:0] p_prod, p_term, pid_acc;
   logic signed [INT_W-1:0] i_term, integ_next;
   logic signed [SAT_W:0]   d_diff;
   logic signed [7:0]       d_sat;
   logic signed [DT_W-1:0]  d_term;
   logic signed [INT_W:0]   integ_sum;
   logic                    integ_clip;
   logic signed [SUM_W-1:0] off, f_ext, sum_l, sum_r;

   always_comb begin
      p_prod     = $signed({{(PID_W-SAT_W){err_sat_p0[SAT_W-1]}}, err_sat_p0})
                 * $signed({{(PID_W-6){1'b0}}, p_coeff});
      p_term     = p_prod >>> 1;
      i_term     = integ >>> I_FRAC;
      d_diff     = $signed({err_sat_p0[SAT_W-1], err_sat_p0})
                 - $signed({hist[D_DEPTH-1][SAT_W-1], hist[D_DEPTH-1]});
      d_sat      = sat8(d_diff);
      d_term     = $signed({{(DT_W-8){d_sat[7]}}, d_sat}) * $signed({{(DT_W-5){1'b0}}, d_coeff});
      pid_acc    = p_term
                 + $signed({{(PID_W-INT_W){i_term[INT_W-1]}}, i_term})
                 + $signed({{(PID_W-DT_W){d_term[DT_W-1]}}, d_term});
      integ_sum  = $signed({integ[INT_W-1], integ})
                 + $signed({{(INT_W+1-SAT_W){err_sat_p0[SAT_W-1]}}, err_sat_p0});
      integ_next = clamp_int(integ_sum);
      integ_clip = (integ_sum > INT_HI) || (integ_sum < INT_LO);
      off        = SUM_W'(pid_p1 >>> 3);
      f_ext      = $signed({{(SUM_W-FRWRD_W){1'b0}}, f_val});
      sum_l      = f_ext + off;
      sum_r      = f_ext - off;
   end

`ifdef FF_RAMP_EN
   localparam logic [FRWRD_W-1:0] STEP = FRWRD_W'(RAMP_STEP);
   logic [FRWRD_W-1:0] ramp, ramp_next;

   always_comb begin
      ramp_next = frwrd;
      if (frwrd > ramp) begin
         if (frwrd - ramp > STEP) ramp_next = ramp + STEP;
      end else if (ramp - frwrd > STEP) begin
         ramp_next = ramp - STEP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           ramp <= '0;
      else if (!moving)  ramp <= '0;
      else if (vld_p0)   ramp <= ramp_next;
   end

   assign f_val = ramp;
`else
   assign f_val = frwrd;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sat_p0 <= '0;
         vld_p0     <= 1'b0;
         pid_p1     <= '0;
         vld_p1     <= 1'b0;
         integ      <= '0;
         int_sat    <= 1'b0;
         for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
         lft_spd    <= '0;
         rght_spd   <= '0;
         spd_vld    <= 1'b0;
      end else begin
         // stage 0: saturate the raw error
         err_sat_p0 <= sat_err(error);
         vld_p0     <= err_vld & moving;
         if (!moving) begin
            pid_p1   <= '0;
            vld_p1   <= 1'b0;
            integ    <= '0;
            int_sat  <= 1'b0;
            for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
         end else begin
            // stage 1: PID sum, integrator and D history advance only on valid samples
            vld_p1 <= vld_p0;
            if (vld_p0) begin
               pid_p1 <= pid_acc;
               integ  <= integ_next;
               if (integ_clip) int_sat <= 1'b1;
               hist[0] <= err_sat_p0;
               for (int k = 1; k < D_DEPTH; k++) hist[k] <= hist[k-1];
            end
            // stage 2: differential steering, recomputed every edge so outputs follow frwrd
            lft_spd  <= clamp_spd(sum_l);
            rght_spd <= clamp_spd(sum_r);
            spd_vld  <= vld_p1;
         end
      end
   end

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// tb_pid_ctrl_gen: scoreboard bench for pid_ctrl_gen in its default build (forward ramp disabled).
module tb_pid_ctrl_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        moving;
   logic        err_vld;
   logic [11:0] error;
   logic [9:0]  frwrd;
   logic [5:0]  p_coeff;
   logic [4:0]  d_coeff;
   logic [10:0] lft_spd;
   logic [10:0] rght_spd;
   logic        spd_vld;
   logic        int_sat;

   pid_ctrl_gen dut (
      .clk      (clk),
      .rst      (rst),
      .moving   (moving),
      .err_vld  (err_vld),
      .error    (error),
      .frwrd    (frwrd),
      .p_coeff  (p_coeff),
      .d_coeff  (d_coeff),
      .lft_spd  (lft_spd),
      .rght_spd (rght_spd),
      .spd_vld  (spd_vld),
      .int_sat  (int_sat)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] l;
      logic [10:0] r;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_x;
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_integ;
   int   m_hist [3];
   bit   m_sat;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   function automatic int clampi(input int x, input int lo, input int hi);
      if (x < lo) return lo;
      if (x > hi) return hi;
      return x;
   endfunction

   task automatic model_clear();
      m_integ = 0;
      foreach (m_hist[k]) m_hist[k] = 0;
      m_sat = 1'b0;
   endtask

   // reference PID in plain integer arithmetic; pushes the speeds the sample must produce
   task automatic model_push(input logic [11:0] e);
      int es, pt, it, dt, pid, off, f, nxt;
      exp_t x;
      es  = clampi(int'($signed(e)), -512, 511);
      pt  = (es * int'(p_coeff)) >>> 1;
      it  = m_integ >>> 6;
      dt  = clampi(es - m_hist[2], -128, 127) * int'(d_coeff);
      pid = pt + it + dt;
      off = pid >>> 3;
      f   = int'(frwrd);
      x.l = 11'(clampi(f + off, 0, 1023));
      x.r = 11'(clampi(f - off, 0, 1023));
      exp_q.push_back(x);
      nxt = m_integ + es;
      if (nxt > 16383) begin
         nxt   = 16383;
         m_sat = 1'b1;
      end else if (nxt < -16384) begin
         nxt   = -16384;
         m_sat = 1'b1;
      end
      m_integ   = nxt;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = es;
   endtask

   task automatic send(input logic v, input logic [11:0] e);
      err_vld = v;
      error   = e;
      if (v) model_push(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      err_vld = 1'b0;
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      exp_q.delete();
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && spd_vld) begin
         if (exp_q.size() == 0) begin
            check_eq("spd_vld_unexpected", spd_vld, 1'b0);
         end else begin
            mon_x = exp_q.pop_front();
            check_eq("sb_lft", lft_spd, mon_x.l);
            check_eq("sb_rght", rght_spd, mon_x.r);
         end
      end
   end

   initial begin
      rst = 1'b1; moving = 1'b0; err_vld = 1'b0; error = '0;
      frwrd = '0; p_coeff = '0; d_coeff = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_lft", lft_spd, 0);
      check_eq("rst_rght", rght_spd, 0);
      check_eq("rst_vld", spd_vld, 0);
      check_eq("rst_int_sat", int_sat, 0);

      // asynchronous reset while samples are in flight
      moving = 1'b1; p_coeff = 6'd16; d_coeff = 5'd3; frwrd = 10'd300;
      for (int i = 0; i < 8; i++) send(i[0], 12'(i * 37));
      rst = 1'b1;
      #1;
      check_eq("arst_lft", lft_spd, 0);
      check_eq("arst_rght", rght_spd, 0);
      check_eq("arst_vld", spd_vld, 0);
      check_eq("arst_int_sat", int_sat, 0);
      exp_q.delete();
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(1'b1, 12'd40);
      check_eq("lat_edge0", spd_vld, 0);
      send(1'b0, 12'd0);
      check_eq("lat_edge1", spd_vld, 0);
      send(1'b0, 12'd0);
      check_eq("lat_edge2", spd_vld, 1);
      idle(3);

      // full-scale positive error, both outputs clamp
      do_reset();
      p_coeff = 6'd16; d_coeff = 5'd7; frwrd = 10'd512;
      send(1'b1, 12'h7FF);
      idle(4);
      check_eq("t2_lft", lft_spd, 1023);
      check_eq("t2_rght", rght_spd, 0);

      // small error, I term still below one LSB on the repeat
      do_reset();
      p_coeff = 6'd16; d_coeff = 5'd0; frwrd = 10'd300;
      send(1'b1, 12'd16);
      idle(4);
      check_eq("t3_lft_a", lft_spd, 316);
      check_eq("t3_rght_a", rght_spd, 284);
      send(1'b1, 12'd16);
      idle(4);
      check_eq("t3_lft_b", lft_spd, 316);
      check_eq("t3_rght_b", rght_spd, 284);

      // integrator wind-up to the clamp
      do_reset();
      p_coeff = 6'd0; d_coeff = 5'd0; frwrd = 10'd400;
      for (int i = 0; i < 32; i++) send(1'b1, 12'd511);
      idle(4);
      check_eq("t4_sat_32", int_sat, 0);
      for (int i = 0; i < 8; i++) send(1'b1, 12'd511);
      idle(4);
      check_eq("t4_sat_40", int_sat, 1);
      check_eq("t4_lft", lft_spd, 431);
      check_eq("t4_rght", rght_spd, 369);

      // moving low clears state and drops an in-flight sample
      send(1'b1, 12'd511);
      moving = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      model_clear();
      check_eq("t5_lft", lft_spd, 0);
      check_eq("t5_rght", rght_spd, 0);
      check_eq("t5_int_sat", int_sat, 0);
      check_eq("t5_vld", spd_vld, 0);
      moving = 1'b1;
      idle(1);
      check_eq("t5_track_lft", lft_spd, 400);
      check_eq("t5_track_rght", rght_spd, 400);
      idle(2);
      d_coeff = 5'd4;
      send(1'b1, 12'd100);
      idle(4);
      check_eq("t5_d_lft", lft_spd, 450);
      check_eq("t5_d_rght", rght_spd, 350);

      // most negative raw error
      do_reset();
      p_coeff = 6'd16; d_coeff = 5'd0; frwrd = 10'd100;
      send(1'b1, 12'h800);
      idle(4);
      check_eq("t6_lft", lft_spd, 0);
      check_eq("t6_rght", rght_spd, 612);

      // random gains, errors and valid gaps
      do_reset();
      for (int s = 0; s < 4; s++) begin
         p_coeff = 6'($urandom_range(0, 63));
         d_coeff = 5'($urandom_range(0, 31));
         frwrd   = 10'($urandom_range(0, 1023));
         for (int i = 0; i < 30; i++) send(1'($urandom_range(0, 1)), 12'($urandom));
         idle(4);
         check_eq("rnd_int_sat", int_sat, m_sat);
      end

      check_eq("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
